// File: rtl/e203_exu_fpu_wbck_pkg.sv
// Shared constants and source encoding for the FPU write-back stage.
// Widths mirror the core-wide XLEN / ITAG settings and the write-back FIFO defaults.
package e203_exu_fpu_wbck_pkg;

  localparam int unsigned E203_XLEN                = 32;
  localparam int unsigned E203_ITAG_WIDTH          = 4;
  localparam int unsigned E203_FPU_WBCK_DEPTH      = 2;
  localparam int unsigned E203_FPU_WBCK_STARVE_LIM = 4;

  // Bit position of each result source within the one-hot grant vector.
  typedef enum logic [1:0] {
    SRC_FMIS = 2'd0,
    SRC_FMAC = 2'd1,
    SRC_FDIV = 2'd2
  } wbck_src_e;

  function automatic logic [2:0] src_onehot(input wbck_src_e src);
    return 3'b001 << src;
  endfunction

endpackage

// File: rtl/e203_exu_fpu_wbck_arb.sv
// Three-way fixed-priority arbiter (fdiv > fmac > fmis).
// A starvation counter promotes a waiting fmis to top priority.
module e203_exu_fpu_wbck_arb
  import e203_exu_fpu_wbck_pkg::*;
#(
  parameter int unsigned STARVE_LIM = E203_FPU_WBCK_STARVE_LIM
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_pulse,
  input  logic       fmis_valid,
  input  logic       fmac_valid,
  input  logic       fdiv_valid,
  input  logic       fmis_ready,
  output logic [2:0] grant
);

  localparam int unsigned CW = $clog2(STARVE_LIM + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          starved;

  assign starved = fmis_valid & (cnt_q == CW'(STARVE_LIM));

  always_comb begin
    grant = '0;
    if (starved)         grant = src_onehot(SRC_FMIS);
    else if (fdiv_valid) grant = src_onehot(SRC_FDIV);
    else if (fmac_valid) grant = src_onehot(SRC_FMAC);
    else if (fmis_valid) grant = src_onehot(SRC_FMIS);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush_pulse | ~fmis_valid | fmis_ready) cnt_d = '0;
    else if (cnt_q != CW'(STARVE_LIM))          cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/e203_exu_fpu_wbck.sv
// FPU result write-back: arbitrates fmis/fmac/fdiv results into a small
// in-order FIFO whose head drives the regfile write-back port.
module e203_exu_fpu_wbck
  import e203_exu_fpu_wbck_pkg::*;
#(
  parameter int unsigned XLEN       = E203_XLEN,
  parameter int unsigned ITAG_W     = E203_ITAG_WIDTH,
  parameter int unsigned DEPTH      = E203_FPU_WBCK_DEPTH,
  parameter int unsigned STARVE_LIM = E203_FPU_WBCK_STARVE_LIM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_pulse,

  input  logic              fmis_o_valid,
  output logic              fmis_o_ready,
  input  logic [XLEN-1:0]   fmis_o_wbck_wdat,
  input  logic              fmis_o_wbck_err,
  input  logic [4:0]        fmis_o_rdidx,
  input  logic              fmis_o_rdfpu,
  input  logic [ITAG_W-1:0] fmis_o_itag,

  input  logic              fmac_o_valid,
  output logic              fmac_o_ready,
  input  logic [XLEN-1:0]   fmac_o_wbck_wdat,
  input  logic              fmac_o_wbck_err,
  input  logic [4:0]        fmac_o_rdidx,
  input  logic              fmac_o_rdfpu,
  input  logic [ITAG_W-1:0] fmac_o_itag,

  input  logic              fdiv_o_valid,
  output logic              fdiv_o_ready,
  input  logic [XLEN-1:0]   fdiv_o_wbck_wdat,
  input  logic              fdiv_o_wbck_err,
  input  logic [4:0]        fdiv_o_rdidx,
  input  logic              fdiv_o_rdfpu,
  input  logic [ITAG_W-1:0] fdiv_o_itag,

  output logic              wbck_o_valid,
  input  logic              wbck_o_ready,
  output logic [XLEN-1:0]   wbck_o_wdat,
  output logic              wbck_o_err,
  output logic [4:0]        wbck_o_rdidx,
  output logic              wbck_o_rdfpu,
  output logic [ITAG_W-1:0] wbck_o_itag,
  output logic              fpu_wbck_busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = XLEN + 1 + 5 + 1 + ITAG_W;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [EW-1:0] push_entry, head;
  logic [2:0]    grant, ready;
  logic          empty, full, pop, push, space;

  e203_exu_fpu_wbck_arb #(.STARVE_LIM(STARVE_LIM)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_pulse (flush_pulse),
    .fmis_valid  (fmis_o_valid),
    .fmac_valid  (fmac_o_valid),
    .fdiv_valid  (fdiv_o_valid),
    .fmis_ready  (fmis_o_ready),
    .grant       (grant)
  );

  // Extra pointer MSB separates full from empty when the index bits match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign wbck_o_valid  = ~empty & ~flush_pulse;
  assign pop           = wbck_o_valid & wbck_o_ready;
  assign space         = ~full | pop;
  assign ready         = grant & {3{space & ~flush_pulse}};
  assign push          = |ready;
  assign fpu_wbck_busy = ~empty;

  assign fmis_o_ready = ready[SRC_FMIS];
  assign fmac_o_ready = ready[SRC_FMAC];
  assign fdiv_o_ready = ready[SRC_FDIV];

  always_comb begin
    push_entry = {fmis_o_wbck_wdat, fmis_o_wbck_err, fmis_o_rdidx, fmis_o_rdfpu, fmis_o_itag};
    if (grant[SRC_FDIV])
      push_entry = {fdiv_o_wbck_wdat, fdiv_o_wbck_err, fdiv_o_rdidx, fdiv_o_rdfpu, fdiv_o_itag};
    else if (grant[SRC_FMAC])
      push_entry = {fmac_o_wbck_wdat, fmac_o_wbck_err, fmac_o_rdidx, fmac_o_rdfpu, fmac_o_itag};
  end

  assign head = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  assign {wbck_o_wdat, wbck_o_err, wbck_o_rdidx, wbck_o_rdfpu, wbck_o_itag} = head;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wptr_q[AW-1:0]] = push_entry;
  end

  always_comb begin
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
    if (flush_pulse) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: tb/tb_e203_exu_fpu_wbck.sv
// Directed, table-driven bench for the FPU write-back stage.
module tb_e203_exu_fpu_wbck;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_pulse = 1'b0;
  logic        fmis_o_valid = 1'b0, fmac_o_valid = 1'b0, fdiv_o_valid = 1'b0;
  logic        fmis_o_ready, fmac_o_ready, fdiv_o_ready;
  logic [31:0] fmis_o_wbck_wdat = '0, fmac_o_wbck_wdat = '0, fdiv_o_wbck_wdat = '0;
  logic        fmis_o_wbck_err = 1'b0, fmac_o_wbck_err = 1'b0, fdiv_o_wbck_err = 1'b0;
  logic [4:0]  fmis_o_rdidx = '0, fmac_o_rdidx = '0, fdiv_o_rdidx = '0;
  logic        fmis_o_rdfpu = 1'b0, fmac_o_rdfpu = 1'b0, fdiv_o_rdfpu = 1'b0;
  logic [3:0]  fmis_o_itag = '0, fmac_o_itag = '0, fdiv_o_itag = '0;
  logic        wbck_o_valid;
  logic        wbck_o_ready = 1'b0;
  logic [31:0] wbck_o_wdat;
  logic        wbck_o_err;
  logic [4:0]  wbck_o_rdidx;
  logic        wbck_o_rdfpu;
  logic [3:0]  wbck_o_itag;
  logic        fpu_wbck_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  e203_exu_fpu_wbck #(
    .XLEN(32), .ITAG_W(4), .DEPTH(2), .STARVE_LIM(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_pulse(flush_pulse),
    .fmis_o_valid(fmis_o_valid), .fmis_o_ready(fmis_o_ready),
    .fmis_o_wbck_wdat(fmis_o_wbck_wdat), .fmis_o_wbck_err(fmis_o_wbck_err),
    .fmis_o_rdidx(fmis_o_rdidx), .fmis_o_rdfpu(fmis_o_rdfpu), .fmis_o_itag(fmis_o_itag),
    .fmac_o_valid(fmac_o_valid), .fmac_o_ready(fmac_o_ready),
    .fmac_o_wbck_wdat(fmac_o_wbck_wdat), .fmac_o_wbck_err(fmac_o_wbck_err),
    .fmac_o_rdidx(fmac_o_rdidx), .fmac_o_rdfpu(fmac_o_rdfpu), .fmac_o_itag(fmac_o_itag),
    .fdiv_o_valid(fdiv_o_valid), .fdiv_o_ready(fdiv_o_ready),
    .fdiv_o_wbck_wdat(fdiv_o_wbck_wdat), .fdiv_o_wbck_err(fdiv_o_wbck_err),
    .fdiv_o_rdidx(fdiv_o_rdidx), .fdiv_o_rdfpu(fdiv_o_rdfpu), .fdiv_o_itag(fdiv_o_itag),
    .wbck_o_valid(wbck_o_valid), .wbck_o_ready(wbck_o_ready),
    .wbck_o_wdat(wbck_o_wdat), .wbck_o_err(wbck_o_err), .wbck_o_rdidx(wbck_o_rdidx),
    .wbck_o_rdfpu(wbck_o_rdfpu), .wbck_o_itag(wbck_o_itag),
    .fpu_wbck_busy(fpu_wbck_busy)
  );

  typedef struct {
    logic        ms_v, mc_v, dv_v, wr, fl;
    logic [7:0]  t;
    logic [2:0]  rdy;   // {fdiv, fmac, fmis}
    logic        wv;
    logic [31:0] wd;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ms, mc, dv, wr, fl, input logic [7:0] t,
                              input logic [2:0] rdy, input logic wv,
                              input logic [31:0] wd, input logic busy);
    vec_t v;
    v.ms_v = ms; v.mc_v = mc; v.dv_v = dv; v.wr = wr; v.fl = fl; v.t = t;
    v.rdy = rdy; v.wv = wv; v.wd = wd; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Each source carries a recognisable data prefix so ordering is visible on wdat.
  task automatic drive(input vec_t v);
    fmis_o_valid = v.ms_v; fmac_o_valid = v.mc_v; fdiv_o_valid = v.dv_v;
    wbck_o_ready = v.wr;   flush_pulse  = v.fl;
    fmis_o_wbck_wdat = 32'hA000_0000 | 32'(v.t);
    fmac_o_wbck_wdat = 32'hB000_0000 | 32'(v.t);
    fdiv_o_wbck_wdat = 32'hC000_0000 | 32'(v.t);
    fmis_o_wbck_err = 1'b0; fmis_o_rdidx = 5'd1; fmis_o_rdfpu = 1'b1; fmis_o_itag = 4'd1;
    fmac_o_wbck_err = 1'b0; fmac_o_rdidx = 5'd2; fmac_o_rdfpu = 1'b1; fmac_o_itag = 4'd2;
    fdiv_o_wbck_err = 1'b0; fdiv_o_rdidx = 5'd3; fdiv_o_rdfpu = 1'b0; fdiv_o_itag = 4'd3;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,0,0,0,8'h00,3'b000,0,32'h0,0);

    // ms mc dv wr fl  t       rdy     wv  wdat          busy
    vecs.push_back(mk(0,0,0,0,0,8'h00,3'b000,0,32'h0,        0)); // reset state
    vecs.push_back(mk(1,0,0,1,0,8'h01,3'b001,0,32'h0,        0));
    vecs.push_back(mk(0,0,0,1,0,8'h00,3'b000,1,32'hA000_0001,1)); // N+1 latency
    vecs.push_back(mk(0,0,0,1,0,8'h00,3'b000,0,32'h0,        0));
    vecs.push_back(mk(0,1,1,1,0,8'h02,3'b100,0,32'h0,        0)); // fdiv beats fmac
    vecs.push_back(mk(0,1,0,1,0,8'h03,3'b010,1,32'hC000_0002,1));
    vecs.push_back(mk(0,0,0,1,0,8'h00,3'b000,1,32'hB000_0003,1));
    vecs.push_back(mk(0,0,0,1,0,8'h00,3'b000,0,32'h0,        0));
    vecs.push_back(mk(1,0,0,0,0,8'h04,3'b001,0,32'h0,        0)); // fill with ready low
    vecs.push_back(mk(1,0,0,0,0,8'h05,3'b001,1,32'hA000_0004,1));
    vecs.push_back(mk(1,0,0,0,0,8'h06,3'b000,1,32'hA000_0004,1)); // full
    vecs.push_back(mk(1,0,0,1,0,8'h06,3'b001,1,32'hA000_0004,1)); // push+pop same cycle
    vecs.push_back(mk(0,0,0,1,0,8'h00,3'b000,1,32'hA000_0005,1));
    vecs.push_back(mk(0,0,0,1,0,8'h00,3'b000,1,32'hA000_0006,1)); // across wrap
    vecs.push_back(mk(0,0,0,1,0,8'h00,3'b000,0,32'h0,        0));
    vecs.push_back(mk(1,0,0,0,0,8'h07,3'b001,0,32'h0,        0));
    vecs.push_back(mk(1,0,0,0,0,8'h08,3'b001,1,32'hA000_0007,1));
    vecs.push_back(mk(1,0,0,1,1,8'h09,3'b000,0,32'hA000_0007,1)); // flush
    vecs.push_back(mk(1,0,0,1,0,8'h09,3'b001,0,32'h0,        0)); // emptied by flush
    vecs.push_back(mk(0,0,0,1,0,8'h00,3'b000,1,32'hA000_0009,1));
    vecs.push_back(mk(0,0,0,1,0,8'h00,3'b000,0,32'h0,        0));
    vecs.push_back(mk(1,1,0,1,0,8'h10,3'b010,0,32'h0,        0)); // fmis starves
    vecs.push_back(mk(1,1,0,1,0,8'h11,3'b010,1,32'hB000_0010,1));
    vecs.push_back(mk(1,1,0,1,0,8'h12,3'b010,1,32'hB000_0011,1));
    vecs.push_back(mk(1,1,0,1,0,8'h13,3'b010,1,32'hB000_0012,1));
    vecs.push_back(mk(1,1,0,1,0,8'h14,3'b001,1,32'hB000_0013,1)); // promoted on 5th
    vecs.push_back(mk(1,1,0,1,0,8'h15,3'b010,1,32'hA000_0014,1)); // counter back to 0
    vecs.push_back(mk(0,0,0,1,0,8'h00,3'b000,1,32'hB000_0015,1));
    vecs.push_back(mk(0,0,0,1,0,8'h00,3'b000,0,32'h0,        0));

    drive(idle);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    next_cycle();

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'({fdiv_o_ready, fmac_o_ready, fmis_o_ready}), 32'(vecs[i].rdy));
      chk($sformatf("v%0d_wvalid", i), 32'(wbck_o_valid), 32'(vecs[i].wv));
      chk($sformatf("v%0d_wdat", i), wbck_o_wdat, vecs[i].wd);
      chk($sformatf("v%0d_busy", i), 32'(fpu_wbck_busy), 32'(vecs[i].busy));
      next_cycle();
    end

    // Field pass-through for an fmis result, then err and x0 via fdiv.
    drive(idle);
    wbck_o_ready = 1'b1;
    fmis_o_valid = 1'b1; fmis_o_wbck_wdat = 32'h3F80_0000; fmis_o_wbck_err = 1'b0;
    fmis_o_rdidx = 5'd5; fmis_o_rdfpu = 1'b1; fmis_o_itag = 4'd1;
    @(negedge clk);
    chk("pt_fmis_ready", 32'(fmis_o_ready), 32'd1);
    next_cycle();
    fmis_o_valid = 1'b0;
    fdiv_o_valid = 1'b1; fdiv_o_wbck_wdat = 32'hDEAD_BEEF; fdiv_o_wbck_err = 1'b1;
    fdiv_o_rdidx = 5'd0; fdiv_o_rdfpu = 1'b0; fdiv_o_itag = 4'd9;
    @(negedge clk);
    chk("pt_valid", 32'(wbck_o_valid), 32'd1);
    chk("pt_wdat", wbck_o_wdat, 32'h3F80_0000);
    chk("pt_err", 32'(wbck_o_err), 32'd0);
    chk("pt_rdidx", 32'(wbck_o_rdidx), 32'd5);
    chk("pt_rdfpu", 32'(wbck_o_rdfpu), 32'd1);
    chk("pt_itag", 32'(wbck_o_itag), 32'd1);
    chk("pt_fdiv_ready", 32'(fdiv_o_ready), 32'd1);
    next_cycle();
    fdiv_o_valid = 1'b0;
    @(negedge clk);
    chk("pt2_wdat", wbck_o_wdat, 32'hDEAD_BEEF);
    chk("pt2_err", 32'(wbck_o_err), 32'd1);
    chk("pt2_rdidx", 32'(wbck_o_rdidx), 32'd0);
    chk("pt2_rdfpu", 32'(wbck_o_rdfpu), 32'd0);
    chk("pt2_itag", 32'(wbck_o_itag), 32'd9);
    next_cycle();
    @(negedge clk);
    chk("pt_empty_busy", 32'(fpu_wbck_busy), 32'd0);
    next_cycle();

    // Asynchronous reset in the middle of operation discards buffered results.
    drive(mk(1,0,0,0,0,8'h33,3'b000,0,32'h0,0));
    next_cycle();
    drive(idle);
    @(negedge clk);
    chk("rst_pre_valid", 32'(wbck_o_valid), 32'd1);
    chk("rst_pre_wdat", wbck_o_wdat, 32'hA000_0033);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(wbck_o_valid), 32'd0);
    chk("rst_mid_busy", 32'(fpu_wbck_busy), 32'd0);
    chk("rst_mid_wdat", wbck_o_wdat, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_post_busy", 32'(fpu_wbck_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/e203_exu_fpu_wbck.md
Name: e203_exu_fpu_wbck

Overview:
- FPU result write-back stage. It sits directly downstream of the FMIS unit and its sibling FPU execution units (FMAC, FDIV).
- Arbitrates the three result streams and buffers accepted results in a small in-order FIFO.
- Presents one registered write-back port to the integer/float regfile write arbiter.
- Drops all buffered results on a pipeline flush.

Parameters:
- XLEN, 32 (`E203_XLEN), result data width.
- ITAG_W, `E203_ITAG_WIDTH, instruction tag width.
- DEPTH, 2, result FIFO entries; power of 2, minimum 2.
- STARVE_LIM, 4, cycles FMIS may wait with valid asserted before it is promoted to top priority.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_pulse  in  1  pipeline flush; drops all buffered and offered results
- For each S in {fmis, fmac, fdiv}:
  - S_o_valid  in  1  result valid
  - S_o_ready  out  1  result accepted
  - S_o_wbck_wdat  in  XLEN  result data
  - S_o_wbck_err  in  1  result error
  - S_o_rdidx  in  5  destination register index
  - S_o_rdfpu  in  1  1 = float regfile, 0 = integer regfile
  - S_o_itag  in  ITAG_W  instruction tag
- wbck_o_valid  out  1  write-back valid
- wbck_o_ready  in  1  regfile arbiter accepts
- wbck_o_wdat  out  XLEN  write-back data
- wbck_o_err  out  1  error
- wbck_o_rdidx  out  5  destination index
- wbck_o_rdfpu  out  1  destination regfile select
- wbck_o_itag  out  ITAG_W  tag
- fpu_wbck_busy  out  1  FIFO non-empty

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low.
- Reset state:
  - read/write pointers = 0; FIFO empty.
  - starvation counter = 0.
  - wbck_o_valid = 0, fpu_wbck_busy = 0, all wbck_o_* data outputs = 0.
- FIFO:
  - Entry = {wdat, err, rdidx, rdfpu, itag}.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally; full/empty are decided by the MSB compare.
  - Head entry drives wbck_o_*. When the FIFO is empty, data outputs are forced to 0.
- Latency: a result accepted in cycle N is presented on wbck_o_valid in cycle N+1 if the FIFO was empty. Back-to-back sustained at 1 result/cycle.
- Push/pop rules:
  - pop = wbck_o_valid & wbck_o_ready.
  - space = ~full | pop. Push into a full FIFO is allowed in the same cycle as a pop.
  - At most one push per cycle.
- Arbitration:
  - Fixed priority fdiv > fmac > fmis.
  - Exception: when the starvation counter equals STARVE_LIM and fmis_o_valid=1, fmis takes top priority.
  - grant is one-hot among valid sources. S_o_ready = grant_S & space & ~flush_pulse.
  - Ready may depend combinationally on valids; no output valid depends on any ready.
- Starvation counter:
  - Increments when fmis_o_valid & ~fmis_o_ready, saturating at STARVE_LIM.
  - Clears on an fmis handshake, on flush_pulse, or when fmis_o_valid=0.
- Flush:
  - In the flush_pulse cycle, wbck_o_valid is forced to 0 and every S_o_ready = 0.
  - Next cycle: pointers = 0, FIFO empty, counter = 0.
  - A flush coincident with a would-be push drops that result.
- Pass-through: err, rdidx (including x0) and rdfpu pass through unmodified; the block performs no filtering.
- Status: fpu_wbck_busy = ~empty.
- Reset mid-operation: asynchronous clear to the reset state; in-flight contents are lost.

Decomposition:
- In e203_defines.v: `E203_FPU_WBCK_DEPTH (2) and `E203_FPU_WBCK_STARVE_LIM (4). Entry field widths are derived from existing `E203_XLEN and `E203_ITAG_WIDTH.
- One sub-module, e203_exu_fpu_wbck_arb: the 3-way priority arbiter plus the starvation counter, outputting a one-hot grant.
- The FIFO stays inline in e203_exu_fpu_wbck.

Test Plan:
- Reset-only -> wbck_o_valid=0, fpu_wbck_busy=0, wbck_o_wdat=0, all S_o_ready=0.
- fmis valid with wdat=32'h3F80_0000, rdidx=5, rdfpu=1, itag=1, wbck_o_ready=1 -> fmis_o_ready=1 in cycle N; cycle N+1 wbck_o_valid=1 with the same fields; FIFO empty in N+2.
- fdiv and fmac valid simultaneously, wbck_o_ready=1 -> fdiv accepted first, fmac one cycle later; outputs in order fdiv, fmac.
- fmac held valid continuously with fmis valid, wbck_o_ready=1 -> fmis blocked for 4 cycles, then accepted on the 5th; counter returns to 0.
- wbck_o_ready=0, three fmis pushes -> two accepted; FIFO full, fmis_o_ready=0 on the 3rd. Then ready=1 -> pop and push occur in the same cycle, and order is preserved across pointer wrap.
- FIFO holding 2 entries, flush_pulse with fmis valid -> wbck_o_valid=0 and fmis_o_ready=0 that cycle; next cycle empty and busy=0; the fmis result is accepted after the flush.
